// File: rtl/store_result_monitor.sv
// ----------------------------------------------------------------------------
// store_result_monitor
//
// Watches the core's data-memory write port and delivers a pass/fail verdict
// for a self-checking program. Stores must hit an ordered table of expected
// (address, data) pairs. Stores into a scratch window are tolerated, and any
// other store is a failure. An ecall/ebreak before the table completes, or a
// watchdog expiry, is also a failure.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   en                    arm (IDLE->RUN); dropping it in RUN aborts to IDLE
//   mem_write             store strobe
//   data_addr, write_data store address / data
//   ecall, ebreak         core trap indications
//   exp_addr, exp_data    packed expected table, entry i at [i*W +: W]
//   pass, fail, done      sticky verdict (done = pass | fail)
//   fail_code             0 none, 1 bad store, 2 ecall, 3 ebreak, 4 timeout
//   match_idx             number of table entries matched so far
//   write_count           stores seen in RUN (saturating)
//   cycle_count           cycles spent in RUN (saturating)
//   last_addr, last_data  most recent store seen in RUN
// ----------------------------------------------------------------------------
module store_result_monitor #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned NUM_CHECKS     = 1,
   parameter logic [ADDR_W-1:0] IGN_LO   = 96,
   parameter logic [ADDR_W-1:0] IGN_HI   = 96,
   parameter int unsigned TIMEOUT_CYCLES = 10000,
   parameter int unsigned CNT_W          = 32,
   localparam int unsigned IDX_W         = $clog2(NUM_CHECKS + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic                           mem_write,
   input  logic [ADDR_W-1:0]              data_addr,
   input  logic [DATA_W-1:0]              write_data,
   input  logic                           ecall,
   input  logic                           ebreak,
   input  logic [NUM_CHECKS*ADDR_W-1:0]   exp_addr,
   input  logic [NUM_CHECKS*DATA_W-1:0]   exp_data,
   output logic                           pass,
   output logic                           fail,
   output logic                           done,
   output logic [2:0]                     fail_code,
   output logic [IDX_W-1:0]               match_idx,
   output logic [CNT_W-1:0]               write_count,
   output logic [CNT_W-1:0]               cycle_count,
   output logic [ADDR_W-1:0]              last_addr,
   output logic [DATA_W-1:0]              last_data
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PASS_S = 2'd2,
      FAIL_S = 2'd3
   } state_t;

   localparam logic [2:0] CODE_STORE   = 3'd1;
   localparam logic [2:0] CODE_ECALL   = 3'd2;
   localparam logic [2:0] CODE_EBREAK  = 3'd3;
   localparam logic [2:0] CODE_TIMEOUT = 3'd4;

   // Last RUN cycle index before the watchdog fires; unused when disabled.
   localparam logic [CNT_W-1:0] TO_LIM =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_t state;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_data;
   logic              hit;
   logic              last_hit;
   logic              in_win;
   logic              bad_store;
   logic              to_hit;

   // Select the table entry currently awaited. match_idx never reaches
   // NUM_CHECKS while in RUN, so the zero default is never consumed there.
   always_comb begin
      cur_addr = '0;
      cur_data = '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
         if (match_idx == IDX_W'(i)) begin
            cur_addr = exp_addr[i*ADDR_W +: ADDR_W];
            cur_data = exp_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // A table hit wins over the scratch window, so an expected store that
   // happens to fall inside the window still advances the match pointer.
   assign hit       = mem_write && (data_addr == cur_addr) && (write_data == cur_data);
   assign last_hit  = hit && (match_idx == IDX_W'(NUM_CHECKS - 1));
   assign in_win    = (data_addr >= IGN_LO) && (data_addr <= IGN_HI);
   assign bad_store = mem_write && !hit && !in_win;
   assign to_hit    = (TIMEOUT_CYCLES != 0) && (cycle_count == TO_LIM);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pass        <= 1'b0;
         fail        <= 1'b0;
         done        <= 1'b0;
         fail_code   <= 3'd0;
         match_idx   <= '0;
         write_count <= '0;
         cycle_count <= '0;
         last_addr   <= '0;
         last_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  state       <= RUN;
                  match_idx   <= '0;
                  write_count <= '0;
                  cycle_count <= '0;
                  last_addr   <= '0;
                  last_data   <= '0;
               end
            end

            RUN: begin
               if (!en) begin
                  // Abort: counters and last_* keep their values for inspection.
                  state <= IDLE;
               end else begin
                  if (mem_write) begin
                     write_count <= sat_inc(write_count);
                     last_addr   <= data_addr;
                     last_data   <= write_data;
                  end
                  if (hit) begin
                     match_idx <= match_idx + IDX_W'(1);
                  end

                  // Completion beats every failure source in the same cycle;
                  // a bad store beats a trap or timeout.
                  if (last_hit) begin
                     state <= PASS_S;
                     pass  <= 1'b1;
                     done  <= 1'b1;
                  end else if (bad_store) begin
                     state     <= FAIL_S;
                     fail      <= 1'b1;
                     done      <= 1'b1;
                     fail_code <= CODE_STORE;
                  end else if (ecall) begin
                     state     <= FAIL_S;
                     fail      <= 1'b1;
                     done      <= 1'b1;
                     fail_code <= CODE_ECALL;
                  end else if (ebreak) begin
                     state     <= FAIL_S;
                     fail      <= 1'b1;
                     done      <= 1'b1;
                     fail_code <= CODE_EBREAK;
                  end else if (to_hit) begin
                     state     <= FAIL_S;
                     fail      <= 1'b1;
                     done      <= 1'b1;
                     fail_code <= CODE_TIMEOUT;
                  end else begin
                     cycle_count <= sat_inc(cycle_count);
                  end
               end
            end

            // PASS_S / FAIL_S are terminal: everything frozen until rst.
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_result_monitor.sv
module tb_store_result_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        en1, en2, en3;
   logic        mem_write;
   logic [31:0] data_addr;
   logic [31:0] write_data;
   logic        ecall, ebreak;

   logic [31:0] exp_addr1, exp_data1;
   logic [95:0] exp_addr3, exp_data3;

   // u1: one entry, default watchdog
   logic pass1, fail1, done1;
   logic [2:0]  code1;
   logic [0:0]  idx1;
   logic [31:0] wc1, cc1, la1, ld1;
   // u2: one entry, 8-cycle watchdog
   logic pass2, fail2, done2;
   logic [2:0]  code2;
   logic [0:0]  idx2;
   logic [31:0] wc2, cc2, la2, ld2;
   // u3: three entries
   logic pass3, fail3, done3;
   logic [2:0]  code3;
   logic [1:0]  idx3;
   logic [31:0] wc3, cc3, la3, ld3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   store_result_monitor #(.NUM_CHECKS(1)) u1 (
      .clk(clk), .rst(rst), .en(en1), .mem_write(mem_write), .data_addr(data_addr),
      .write_data(write_data), .ecall(ecall), .ebreak(ebreak),
      .exp_addr(exp_addr1), .exp_data(exp_data1),
      .pass(pass1), .fail(fail1), .done(done1), .fail_code(code1), .match_idx(idx1),
      .write_count(wc1), .cycle_count(cc1), .last_addr(la1), .last_data(ld1));

   store_result_monitor #(.NUM_CHECKS(1), .TIMEOUT_CYCLES(8)) u2 (
      .clk(clk), .rst(rst), .en(en2), .mem_write(mem_write), .data_addr(data_addr),
      .write_data(write_data), .ecall(ecall), .ebreak(ebreak),
      .exp_addr(exp_addr1), .exp_data(exp_data1),
      .pass(pass2), .fail(fail2), .done(done2), .fail_code(code2), .match_idx(idx2),
      .write_count(wc2), .cycle_count(cc2), .last_addr(la2), .last_data(ld2));

   store_result_monitor #(.NUM_CHECKS(3)) u3 (
      .clk(clk), .rst(rst), .en(en3), .mem_write(mem_write), .data_addr(data_addr),
      .write_data(write_data), .ecall(ecall), .ebreak(ebreak),
      .exp_addr(exp_addr3), .exp_data(exp_data3),
      .pass(pass3), .fail(fail3), .done(done3), .fail_code(code3), .match_idx(idx3),
      .write_count(wc3), .cycle_count(cc3), .last_addr(la3), .last_data(ld3));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   // Advance one rising edge, then settle so outputs are sampled off the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
      mem_write = 1'b0; ecall = 1'b0; ebreak = 1'b0;
      data_addr = '0; write_data = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      mem_write = 1'b1; data_addr = a; write_data = d;
      tick();
      mem_write = 1'b0;
   endtask

   task automatic check_u1_zero(input string tag);
      check({tag, ".pass"}, pass1, 0);
      check({tag, ".fail"}, fail1, 0);
      check({tag, ".done"}, done1, 0);
      check({tag, ".code"}, code1, 0);
      check({tag, ".idx"},  idx1, 0);
      check({tag, ".wc"},   wc1, 0);
      check({tag, ".cc"},   cc1, 0);
      check({tag, ".la"},   la1, 0);
      check({tag, ".ld"},   ld1, 0);
   endtask

   task automatic run_case1(input string tag);
      en1 = 1'b1; tick();
      store(32'd96, 32'd7);
      check({tag, ".pre_pass"}, pass1, 0);
      store(32'd100, 32'd25);
      check({tag, ".pass"}, pass1, 1);
      check({tag, ".fail"}, fail1, 0);
      check({tag, ".done"}, done1, 1);
      check({tag, ".code"}, code1, 0);
      check({tag, ".wc"},   wc1, 2);
      check({tag, ".idx"},  idx1, 1);
      check({tag, ".la"},   la1, 100);
      check({tag, ".ld"},   ld1, 25);
      check({tag, ".cc"},   cc1, 1);
   endtask

   initial begin
      exp_addr1 = 32'd100; exp_data1 = 32'd25;
      exp_addr3 = {32'd108, 32'd104, 32'd100};
      exp_data3 = {32'd3,   32'd2,   32'd1};

      // Reset state
      do_reset();
      check_u1_zero("rst");

      // 1: scratch store then expected store
      run_case1("t1");
      store(32'd104, 32'd3);
      check("t1.frozen_fail", fail1, 0);
      check("t1.frozen_wc",   wc1, 2);

      // 2: unexpected store, later stores ignored
      do_reset();
      en1 = 1'b1; tick();
      store(32'd104, 32'd3);
      check("t2.fail", fail1, 1);
      check("t2.code", code1, 1);
      check("t2.la",   la1, 104);
      check("t2.done", done1, 1);
      store(32'd100, 32'd25);
      check("t2.no_pass", pass1, 0);
      check("t2.la_hold", la1, 104);
      check("t2.wc_hold", wc1, 1);
      check("t2.idx",     idx1, 0);

      // 3a: ebreak before match
      do_reset();
      en1 = 1'b1; tick();
      ebreak = 1'b1; tick(); ebreak = 1'b0;
      check("t3a.fail", fail1, 1);
      check("t3a.code", code1, 3);

      // 3b: ecall in the same cycle as the completing store
      do_reset();
      en1 = 1'b1; tick();
      ecall = 1'b1; store(32'd100, 32'd25); ecall = 1'b0;
      check("t3b.pass", pass1, 1);
      check("t3b.fail", fail1, 0);
      check("t3b.code", code1, 0);

      // 3c: ecall + ebreak together -> ecall code
      do_reset();
      en1 = 1'b1; tick();
      ecall = 1'b1; ebreak = 1'b1; tick(); ecall = 1'b0; ebreak = 1'b0;
      check("t3c.code", code1, 2);

      // 3d: bad store + ecall -> store code
      do_reset();
      en1 = 1'b1; tick();
      ecall = 1'b1; store(32'd200, 32'd1); ecall = 1'b0;
      check("t3d.code", code1, 1);

      // 3e: in-window store with ecall -> ecall code
      do_reset();
      en1 = 1'b1; tick();
      ecall = 1'b1; store(32'd96, 32'd9); ecall = 1'b0;
      check("t3e.code", code1, 2);
      check("t3e.wc",   wc1, 1);

      // 4: watchdog, 8 cycles after RUN entry
      do_reset();
      en2 = 1'b1; tick();
      check("t4.cc_entry", cc2, 0);
      for (int i = 0; i < 7; i++) tick();
      check("t4.done_early", done2, 0);
      check("t4.cc_pre", cc2, 7);
      tick();
      check("t4.done", done2, 1);
      check("t4.fail", fail2, 1);
      check("t4.code", code2, 4);
      check("t4.cc",   cc2, 7);
      tick();
      check("t4.cc_frozen", cc2, 7);

      // 5a: out-of-order table
      do_reset();
      en3 = 1'b1; tick();
      store(32'd100, 32'd1);
      check("t5a.idx1", idx3, 1);
      store(32'd108, 32'd3);
      check("t5a.fail", fail3, 1);
      check("t5a.code", code3, 1);
      check("t5a.idx",  idx3, 1);

      // 5b: in-order table
      do_reset();
      en3 = 1'b1; tick();
      store(32'd100, 32'd1);
      store(32'd96, 32'd0);
      store(32'd104, 32'd2);
      check("t5b.pass_early", pass3, 0);
      store(32'd108, 32'd3);
      check("t5b.pass", pass3, 1);
      check("t5b.idx",  idx3, 3);
      check("t5b.wc",   wc3, 4);
      check("t5b.fail", fail3, 0);

      // Wrong data at right address is a bad store
      do_reset();
      en3 = 1'b1; tick();
      store(32'd100, 32'd2);
      check("t5c.code", code3, 1);
      check("t5c.idx",  idx3, 0);

      // Abort: counters hold, no verdict; re-arm clears
      do_reset();
      en1 = 1'b1; tick();
      store(32'd96, 32'd7);
      en1 = 1'b0; tick();
      check("abort.done", done1, 0);
      check("abort.wc",   wc1, 1);
      check("abort.la",   la1, 96);
      store(32'd104, 32'd3);
      check("abort.idle_wc", wc1, 1);
      check("abort.idle_fail", fail1, 0);
      en1 = 1'b1; tick();
      check("abort.rearm_wc", wc1, 0);
      check("abort.rearm_la", la1, 0);

      // 6: rst mid-RUN after two stores, then re-arm
      do_reset();
      en1 = 1'b1; tick();
      store(32'd96, 32'd7);
      store(32'd96, 32'd8);
      check("t6.wc_before", wc1, 2);
      rst = 1'b1; tick(); rst = 1'b0;
      check_u1_zero("t6");
      run_case1("t6.rerun");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
